can_tx_queue: RTL and testbench

//  Transmit byte queue sitting directly upstream of can_controller.

---
 rtl/can_pkg.sv | 12 +
 rtl/can_sync_fifo.sv | 64 ++++++
 rtl/can_tx_queue.sv | 138 +++++++++++++
 tb/tb_can_tx_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared constants and state encoding for the CAN transmit path.
package can_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } txq_state_t;

endpackage

// File: rtl/can_sync_fifo.sv
// Synchronous show-ahead FIFO: head_c always presents the oldest entry.
// Count carries one extra bit so that full and empty are distinguishable.
module can_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       head_c,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              full_q;
  logic              empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from the next count so they line up with count_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/can_tx_queue.sv
// Transmit byte queue feeding can_controller: one tx_req per byte, waits for
// tx_done, retries on timeout and drops the byte after MAX_RETRY retries.
module can_tx_queue #(
  parameter int unsigned DATA_W    = can_pkg::DATA_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      ctrl_data,
  output logic                   ctrl_tx_req,
  input  logic                   ctrl_tx_done,
  output logic                   busy,
  output logic                   err_ovf,
  output logic                   err_drop,
  input  logic                   clr_err
);

  import can_pkg::*;

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  txq_state_t        state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [RTY_W-1:0]  retry_q;
  logic              req_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic              err_ovf_q;
  logic              err_drop_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_c;
  logic              push_c;
  logic              tmo_hit_c;
  logic              drop_c;
  logic              pop_c;

  // A write is refused whenever the queue is full, even if a pop coincides.
  assign push_c    = wr_en && !fifo_full;
  assign tmo_hit_c = (state_q == WAIT) && !ctrl_tx_done && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign drop_c    = tmo_hit_c && (retry_q >= RTY_W'(MAX_RETRY));
  assign pop_c     = ((state_q == WAIT) && ctrl_tx_done) || drop_c;

  can_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push_c),
    .push_data_i (wr_data),
    .pop_i       (pop_c),
    .head_c      (head_c),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          retry_q <= '0;
          if (!fifo_empty) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            data_q  <= head_c;
          end
        end
        REQ: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          // tx_done takes priority over a coincident timeout.
          if (ctrl_tx_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_hit_c) begin
            if (drop_c) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              retry_q <= retry_q + RTY_W'(1);
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a set event overrides a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      if (wr_en && fifo_full) err_ovf_q <= 1'b1;
      else if (clr_err)       err_ovf_q <= 1'b0;
      if (drop_c)             err_drop_q <= 1'b1;
      else if (clr_err)       err_drop_q <= 1'b0;
    end
  end

  assign full        = fifo_full;
  assign empty       = fifo_empty;
  assign ctrl_data   = data_q;
  assign ctrl_tx_req = req_q;
  assign busy        = busy_q;
  assign err_ovf     = err_ovf_q;
  assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_can_tx_queue.sv
// Directed bench for can_tx_queue with hand-computed cycle and data expectations.
module tb_can_tx_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] ctrl_data;
  logic       ctrl_tx_req;
  logic       ctrl_tx_done;
  logic       busy;
  logic       err_ovf;
  logic       err_drop;
  logic       clr_err;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int idx    = 0;
  int req_cyc[$];
  logic [7:0] req_dat[$];
  int done_cyc[$];

  always #5 clk = ~clk;

  can_tx_queue #(
    .DATA_W    (8),
    .DEPTH     (8),
    .TIMEOUT   (64),
    .MAX_RETRY (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ctrl_data    (ctrl_data),
    .ctrl_tx_req  (ctrl_tx_req),
    .ctrl_tx_done (ctrl_tx_done),
    .busy         (busy),
    .err_ovf      (err_ovf),
    .err_drop     (err_drop),
    .clr_err      (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock and log every request pulse seen.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ctrl_tx_req) begin
      req_cyc.push_back(cyc);
      req_dat.push_back(ctrl_data);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req_cyc.delete();
    req_dat.delete();
    done_cyc.delete();
    idx = 0;
  endtask

  // Wait for the next request, check its byte, hold for `hold` cycles, then complete it.
  task automatic serve(input logic [7:0] exp, input int hold, input string tag);
    int n = 0;
    while (req_dat.size() <= idx && n < 300) begin
      tick();
      n++;
    end
    if (req_dat.size() <= idx) begin
      chk({tag, "_req_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_data"}, 32'(req_dat[idx]), 32'(exp));
    idx++;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, 32'(ctrl_data), 32'(exp));
    end
    ctrl_tx_done = 1'b1;
    done_cyc.push_back(cyc);
    tick();
    ctrl_tx_done = 1'b0;
  endtask

  initial begin
    int r0;
    int e_cyc;
    int d_cyc;
    int n;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    ctrl_tx_done = 1'b0;
    clr_err      = 1'b0;
    tick();

    // Reset state
    chk("rst_req",   32'(ctrl_tx_req), 32'd0);
    chk("rst_empty", 32'(empty),       32'd1);
    chk("rst_full",  32'(full),        32'd0);
    chk("rst_count", 32'(count),       32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_data",  32'(ctrl_data),   32'd0);
    chk("rst_errs",  32'({err_ovf, err_drop}), 32'd0);

    // 1: single byte, tx_done 10 cycles after the request
    do_reset();
    wr(8'hA5);
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_noreq_yet", 32'(ctrl_tx_req), 32'd0);
    tick();
    chk("t1_req_latency", 32'(ctrl_tx_req), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    serve(8'hA5, 10, "t1");
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty",  32'(empty), 32'd1);
    chk("t1_busy0",  32'(busy),  32'd0);
    repeat (5) tick();
    chk("t1_one_req", 32'(req_cyc.size()), 32'd1);
    chk("t1_errs", 32'({err_ovf, err_drop}), 32'd0);

    // 2: three bytes back-to-back, served in order, 2-cycle gap after each tx_done
    do_reset();
    wr(8'hA5);
    wr(8'h3C);
    wr(8'h7E);
    serve(8'hA5, 3, "t2a");
    serve(8'h3C, 3, "t2b");
    serve(8'h7E, 3, "t2c");
    repeat (3) tick();
    chk("t2_nreq", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() == 3 && done_cyc.size() == 3) begin
      chk("t2_gap1", 32'(req_cyc[1] - done_cyc[0]), 32'd2);
      chk("t2_gap2", 32'(req_cyc[2] - done_cyc[1]), 32'd2);
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: overflow, set-beats-clear, write rejected while full despite same-cycle pop
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'(i));
    chk("t3_full",  32'(full),    32'd1);
    chk("t3_cnt8",  32'(count),   32'd8);
    chk("t3_ovf0",  32'(err_ovf), 32'd0);
    wr(8'h08);
    chk("t3_ovf1",  32'(err_ovf), 32'd1);
    chk("t3_cnt8b", 32'(count),   32'd8);
    clr_err = 1'b1;
    wr(8'h09);
    clr_err = 1'b0;
    chk("t3_set_wins", 32'(err_ovf), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_clr", 32'(err_ovf), 32'd0);
    wr_en        = 1'b1;
    wr_data      = 8'hEE;
    ctrl_tx_done = 1'b1;
    tick();
    wr_en        = 1'b0;
    ctrl_tx_done = 1'b0;
    chk("t3_pop_cnt7", 32'(count),   32'd7);
    chk("t3_pop_full", 32'(full),    32'd0);
    chk("t3_pop_ovf",  32'(err_ovf), 32'd1);
    chk("t3_first",    32'(req_dat.size() > 0 ? req_dat[0] : 8'hFF), 32'h00);
    idx = 1;
    for (int i = 1; i < 8; i++) serve(8'(i), 1, "t3_drain");
    repeat (3) tick();
    chk("t3_drained", 32'(empty), 32'd1);
    chk("t3_nreq",    32'(req_cyc.size()), 32'd8);

    // 4: tx_done never returned -> requests at 0, 65, 130; drop decided in cycle 194
    do_reset();
    wr(8'h55);
    e_cyc = -1;
    d_cyc = -1;
    n = 0;
    while (n < 260) begin
      tick();
      n++;
      if (req_cyc.size() > 0 && e_cyc < 0 && empty)    e_cyc = cyc;
      if (req_cyc.size() > 0 && d_cyc < 0 && err_drop) d_cyc = cyc;
    end
    chk("t4_nreq", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() == 3) begin
      r0 = req_cyc[0];
      chk("t4_retry1", 32'(req_cyc[1] - r0), 32'd65);
      chk("t4_retry2", 32'(req_cyc[2] - r0), 32'd130);
      chk("t4_data2",  32'(req_dat[2]),      32'h55);
      // Flags are sampled the cycle after the decision
      chk("t4_empty_at", 32'(e_cyc - r0), 32'd195);
      chk("t4_drop_at",  32'(d_cyc - r0), 32'd195);
    end
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ovf",  32'(err_ovf), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_drop_clr", 32'(err_drop), 32'd0);

    // 5: tx_done on the final timeout cycle wins over the drop
    do_reset();
    wr(8'h5A);
    n = 0;
    while (req_cyc.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    r0 = (req_cyc.size() > 0) ? req_cyc[0] : cyc;
    n = 0;
    while (cyc < r0 + 194 && n < 300) begin
      tick();
      n++;
    end
    ctrl_tx_done = 1'b1;
    tick();
    ctrl_tx_done = 1'b0;
    chk("t5_empty", 32'(empty),    32'd1);
    chk("t5_nodrop", 32'(err_drop), 32'd0);
    chk("t5_busy",  32'(busy),     32'd0);
    repeat (10) tick();
    chk("t5_nreq", 32'(req_cyc.size()), 32'd3);

    // 6: async reset mid-transfer flushes the queue
    do_reset();
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    repeat (3) tick();
    chk("t6_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_cnt",   32'(count), 32'd0);
    chk("t6_async_empty", 32'(empty), 32'd1);
    chk("t6_async_busy",  32'(busy),  32'd0);
    tick();
    reset = 1'b0;
    n = req_cyc.size();
    repeat (20) tick();
    chk("t6_no_resend", 32'(req_cyc.size() - n), 32'd0);
    wr(8'h99);
    tick();
    chk("t6_new_req", 32'(ctrl_tx_req), 32'd1);
    chk("t6_new_data", 32'(ctrl_data), 32'h99);
    reset = 1'b1;
    #1;
    chk("t6_req_async", 32'(ctrl_tx_req), 32'd0);
    tick();
    reset = 1'b0;
    n = req_cyc.size();
    repeat (10) tick();
    chk("t6_no_resend2", 32'(req_cyc.size() - n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
